gemm_c_writeback: RTL
=====================

Name: gemm_c_writeback

Overview:
- Receiver for the GeMM accelerator's result-tile write interface.
- Captures each completed M×N output tile, written in one cycle as a wide array, into a 2-slot tile buffer.
- Serialises the tile into single-word writes toward the C SRAM over a req/gnt handshake, using row-major addressing with a run-time row stride.
- Sits between the accelerator core and the C memory port. Decouples the accelerator's burst writes from a one-word-per-cycle memory.

Parameters:
- OutDataWidth, 32, width of one C element / memory word.
- AddrWidth, 16, width of tile base and memory word addresses.
- SizeAddrWidth, 8, width of the row-stride input.
- M, 4, tile rows.
- N, 4, tile columns.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tile_we_i  in  1  tile write strobe from accelerator.
- tile_base_i  in  AddrWidth  C address of tile element (0,0).
- tile_stride_i  in  SizeAddrWidth  row stride in words (full-matrix N_size).
- tile_data_i  in  OutDataWidth × M*N (unpacked [0:M*N-1])  tile elements, row-major, index m*N+n.
- tile_ready_o  out  1  at least one buffer slot is free.
- mem_req_o  out  1  write request valid.
- mem_addr_o  out  AddrWidth  write word address.
- mem_wdata_o  out  OutDataWidth  write data.
- mem_gnt_i  in  1  memory accepts the current request this cycle.
- idle_o  out  1  both slots empty and no request pending.
- overflow_o  out  1  sticky: a tile was dropped.

Behaviour:
- Reset values: all outputs 0 except tile_ready_o=1 and idle_o=1; slots empty; pointers and counters 0.
- Accept: tile_we_i && tile_ready_o at a rising edge writes data, base and stride into slot wr_ptr. wr_ptr toggles; occupancy increments.
- Overflow:
  - tile_we_i while tile_ready_o=0 drops the tile and sets overflow_o.
  - overflow_o clears only on reset.
- tile_ready_o = (occupancy < 2), registered. A slot freed in cycle t is visible as ready in cycle t+1 (no same-cycle bypass).
- FSM states: IDLE, DRAIN.
  - IDLE→DRAIN when occupancy > 0.
  - DRAIN→IDLE after the last element handshake when occupancy becomes 0.
  - Otherwise DRAIN continues with the next slot, with no bubble cycle.
- Latency: first mem_req_o is asserted the cycle after the accept edge.
- Drain order: elem counter e = 0..M*N-1, with m = e / N and n = e % N, implemented as nested m/n counters (no divider).
  - mem_addr_o = base + m*stride + n, truncated modulo 2^AddrWidth (wrap-around permitted).
  - mem_wdata_o = slot[rd_ptr][e].
- Handshake:
  - mem_req_o stays high with addr/wdata stable until mem_gnt_i.
  - A transfer occurs when mem_req_o && mem_gnt_i; e advances only on transfer.
  - mem_gnt_i while mem_req_o=0 is ignored.
- End of tile: the transfer at e = M*N-1 frees slot rd_ptr, toggles rd_ptr, decrements occupancy and resets e to 0.
- Simultaneous accept and tile completion in the same cycle: occupancy remains unchanged, both operations take effect.
- idle_o = (occupancy==0) && !mem_req_o.
- Asynchronous reset mid-drain: the in-flight tile and buffered tile are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: GEMM_WB_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles_o (32 bits) and tiles_done_o (16 bits), both reset to 0 and saturating.
  - stall_cycles_o counts cycles with mem_req_o && !mem_gnt_i.
  - tiles_done_o counts completed tiles.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gemm_pkg:
  - tile_elems_t typedef (OutDataWidth element array [0:M*N-1]).
  - wb_state_e enum {IDLE, DRAIN}.
  - localparam TileElems = M*N and its index width $clog2(M*N).
- One natural sub-module, gemm_wb_addr_gen:
  - m/n counters plus a running row-base accumulator (row_base += stride on row wrap), avoiding a multiplier.
  - Outputs address, last_o and e index.

Test Plan:
- Single tile: base=0x0010, stride=4, data[i]=i+1, gnt always 1 → 16 writes in cycles 1..16 after accept, addresses 0x10..0x1F, data 1..16, then idle_o=1.
- Stride > N: stride=8, base=0 → addresses 0-3, 8-11, 16-19, 24-27 in order.
- Backpressure: gnt toggles 1,0,1,0 → each word held stable while gnt=0; 16 writes over 32 cycles with no loss or duplication.
- Back-to-back tiles: two accepts two cycles apart, gnt=1 → 32 consecutive writes with no gap between tiles; a third tile_we_i before the first tile completes leaves tile_ready_o=0, sets overflow_o=1 and drops the tile.
- Wrap: base=0xFFFE, stride=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, ...
- Reset mid-drain: assert rst_ni=0 at element 5 → mem_req_o=0, idle_o=1, tile_ready_o=1 immediately; with GEMM_WB_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and default geometry for the GeMM C-tile writeback path.
package gemm_pkg;

  localparam int GemmOutDataWidth  = 32;
  localparam int GemmAddrWidth     = 16;
  localparam int GemmSizeAddrWidth = 8;
  localparam int GemmM             = 4;
  localparam int GemmN             = 4;

  localparam int TileElems    = GemmM * GemmN;
  localparam int TileIdxWidth = $clog2(TileElems);

  typedef logic [GemmOutDataWidth-1:0] tile_elems_t [0:TileElems-1];

  typedef enum logic {
    IDLE,
    DRAIN
  } wb_state_e;

endpackage

// File: rtl/gemm_wb_addr_gen.sv
// rtl/gemm_wb_addr_gen.sv - row-major element walker for one tile.
// A running row base (+= stride per row) replaces the m*stride multiply.
module gemm_wb_addr_gen
  import gemm_pkg::*;
#(
  parameter int AddrWidth     = GemmAddrWidth,
  parameter int SizeAddrWidth = GemmSizeAddrWidth,
  parameter int M             = GemmM,
  parameter int N             = GemmN,
  parameter int IdxWidth      = $clog2(M * N)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AddrWidth-1:0]     base_i,
  input  logic [SizeAddrWidth-1:0] stride_i,
  input  logic                     advance_i,
  output logic [AddrWidth-1:0]     addr_o,
  output logic                     last_o,
  output logic [IdxWidth-1:0]      elem_o
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  logic [MW-1:0]        m_q;
  logic [NW-1:0]        n_q;
  logic [IdxWidth-1:0]  e_q;
  logic [AddrWidth-1:0] row_q;

  assign last_o = (m_q == MW'(M - 1)) && (n_q == NW'(N - 1));
  assign addr_o = base_i + row_q + AddrWidth'(n_q);
  assign elem_o = e_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q   <= '0;
      n_q   <= '0;
      e_q   <= '0;
      row_q <= '0;
    end else if (advance_i) begin
      if (last_o) begin
        m_q   <= '0;
        n_q   <= '0;
        e_q   <= '0;
        row_q <= '0;
      end else begin
        e_q <= e_q + 1'b1;
        if (n_q == NW'(N - 1)) begin
          n_q   <= '0;
          m_q   <= m_q + 1'b1;
          row_q <= row_q + AddrWidth'(stride_i);
        end else begin
          n_q <= n_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_c_writeback.sv
// rtl/gemm_c_writeback.sv - captures M x N result tiles into a 2-slot buffer and drains them word by word to C SRAM.
// Optional GEMM_WB_PERF_CNT_EN adds saturating stall-cycle and completed-tile counters.
module gemm_c_writeback
  import gemm_pkg::*;
#(
  parameter int OutDataWidth  = GemmOutDataWidth,
  parameter int AddrWidth     = GemmAddrWidth,
  parameter int SizeAddrWidth = GemmSizeAddrWidth,
  parameter int M             = GemmM,
  parameter int N             = GemmN
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     tile_we_i,
  input  logic [AddrWidth-1:0]     tile_base_i,
  input  logic [SizeAddrWidth-1:0] tile_stride_i,
  input  logic [OutDataWidth-1:0]  tile_data_i [M*N],
  output logic                     tile_ready_o,
  output logic                     mem_req_o,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [OutDataWidth-1:0]  mem_wdata_o,
  input  logic                     mem_gnt_i,
  output logic                     idle_o,
  output logic                     overflow_o
`ifdef GEMM_WB_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles_o,
  output logic [15:0]              tiles_done_o
`endif
);

  localparam int Elems    = M * N;
  localparam int IdxWidth = $clog2(Elems);

  logic [OutDataWidth-1:0]  slot_data   [2][Elems];
  logic [AddrWidth-1:0]     slot_base   [2];
  logic [SizeAddrWidth-1:0] slot_stride [2];

  logic [1:0]          occ_q, occ_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic                ready_q, overflow_q;
  wb_state_e           state_q, state_d;
  logic                accept, xfer, done, last;
  logic [AddrWidth-1:0] gen_addr;
  logic [IdxWidth-1:0] elem;

  assign accept = tile_we_i & ready_q;
  assign xfer   = mem_req_o & mem_gnt_i;
  assign done   = xfer & last;
  assign occ_d  = occ_q + 2'(accept) - 2'(done);

  gemm_wb_addr_gen #(
    .AddrWidth    (AddrWidth),
    .SizeAddrWidth(SizeAddrWidth),
    .M            (M),
    .N            (N),
    .IdxWidth     (IdxWidth)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .base_i   (slot_base[rd_ptr_q]),
    .stride_i (slot_stride[rd_ptr_q]),
    .advance_i(xfer),
    .addr_o   (gen_addr),
    .last_o   (last),
    .elem_o   (elem)
  );

  // Tile payload needs no reset: it is only observed through a gated mem_wdata_o.
  always_ff @(posedge clk_i) begin
    if (accept) slot_data[wr_ptr_q] <= tile_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ready_q     <= 1'b1;
      overflow_q  <= 1'b0;
      slot_base   <= '{default: '0};
      slot_stride <= '{default: '0};
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d < 2'd2);
      if (tile_we_i && !ready_q) overflow_q <= 1'b1;
      if (accept) begin
        slot_base[wr_ptr_q]   <= tile_base_i;
        slot_stride[wr_ptr_q] <= tile_stride_i;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (done) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Entering DRAIN on the accept edge itself gives the one-cycle request latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (occ_d != 2'd0) state_d = DRAIN;
      DRAIN:   if (done && occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = (state_q == DRAIN);
    mem_addr_o   = mem_req_o ? gen_addr : '0;
    mem_wdata_o  = mem_req_o ? slot_data[rd_ptr_q][elem] : '0;
    idle_o       = (occ_q == 2'd0) && !mem_req_o;
    tile_ready_o = ready_q;
    overflow_o   = overflow_q;
  end

`ifdef GEMM_WB_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] tiles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      tiles_q <= '0;
    end else begin
      if (mem_req_o && !mem_gnt_i && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (done && tiles_q != '1) tiles_q <= tiles_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign tiles_done_o   = tiles_q;
`endif

endmodule
